clock_time_counter: RTL and testbench

- Timekeeping core of the TT clock design; directly upstream of the seven-segment display/scan stage, which consumes its BCD time, colon blink and second tick.
- Divides the 32.768 kHz board clock to a 1 Hz tick and keeps 24-hour HH:MM:SS in packed BCD.
- Accepts a validated time-load strobe, plus minute/hour advance pulses from the debounced buttons while stopped.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/bcd_mod_counter.sv | 30 +++
 rtl/clock_time_counter.sv | 99 +++++++++
 tb/tb_clock_time_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the clock timekeeping core.
package clock_pkg;

    localparam int CLK_HZ_DEFAULT = 32768;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Both nibbles must be decimal digits; the packed value then orders like
    // the decimal value, so a plain compare against the limit is exact.
    function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] val);
        if (val[3:0] == 4'd9)
            return {val[7:4] + 4'd1, 4'd0};
        else
            return {val[7:4], val[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping from MAX to 0x00, with load.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] r_value;

    always_ff @(posedge clk) begin
        if (rst)
            r_value <= 8'h00;
        else if (load)
            r_value <= load_val;
        else if (inc)
            r_value <= (r_value == MAX) ? 8'h00 : bcd_inc(r_value);
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX);

endmodule

// File: rtl/clock_time_counter.sv
// 1 Hz prescaler plus HH:MM:SS BCD timekeeping with load and stopped-mode advance.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int PW     = $clog2(CLK_HZ)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       set_valid,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic       adv_min,
    input  logic       adv_hour,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       sec_tick,
    output logic       blink,
    output logic       set_err
);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic          r_set_err;

    logic w_tc;
    logic w_load;
    logic w_adv;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_hour_inc;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_unused_day_carry;

    // A valid load overrides everything below reset; advances only count while stopped.
    assign w_tc       = ena && (r_presc == PRESC_LAST);
    assign w_load     = set_valid && bcd_valid(set_hour, HOUR_MAX) && bcd_valid(set_min, MIN_MAX);
    assign w_adv      = !ena && !set_valid;
    assign w_sec_inc  = w_tc && !w_load;
    assign w_min_inc  = w_sec_carry || (w_adv && adv_min);
    // Minute carry only ripples into the hour on the running path, never from adv_min.
    assign w_hour_inc = (w_min_carry && ena) || (w_adv && adv_hour);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
            r_set_err  <= 1'b0;
        end else begin
            r_sec_tick <= w_sec_inc;
            r_set_err  <= set_valid && !w_load;
            if (w_load)
                r_presc <= '0;
            else if (ena)
                r_presc <= w_tc ? '0 : r_presc + 1'b1;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_sec_inc),
        .load     (w_load),
        .load_val (8'h00),
        .value    (sec_bcd),
        .carry    (w_sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_min_inc),
        .load     (w_load),
        .load_val (set_min),
        .value    (min_bcd),
        .carry    (w_min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_hour_inc),
        .load     (w_load),
        .load_val (set_hour),
        .value    (hour_bcd),
        .carry    (w_unused_day_carry)
    );

    assign sec_tick = r_sec_tick;
    assign set_err  = r_set_err;
    assign blink    = (r_presc < PRESC_HALF);

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter at CLK_HZ=4: directed vector table, corner sequences, random run.
module tb_clock_time_counter;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hour = 8'h00;
    logic [7:0] set_min = 8'h00;
    logic       adv_min = 1'b0;
    logic       adv_hour = 1'b0;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       sec_tick;
    logic       blink;
    logic       set_err;

    int errors = 0;
    int checks = 0;

    logic [26:0] exp_q[$];

    clock_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .adv_min   (adv_min),
        .adv_hour  (adv_hour),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .sec_tick  (sec_tick),
        .blink     (blink),
        .set_err   (set_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: time as seconds-of-day ----------------
    int m_t = 0;
    int m_presc = 0;
    bit m_tick = 0;
    bit m_err = 0;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic bit field_ok(input logic [7:0] b, input int limit);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd2int(b) <= limit);
    endfunction

    function automatic void model_step(input logic r, e, sv, input logic [7:0] sh, sm,
                                       input logic am, ah);
        int h, m, s;
        if (r) begin
            m_t = 0; m_presc = 0; m_tick = 0; m_err = 0;
        end else if (sv && field_ok(sh, 23) && field_ok(sm, 59)) begin
            m_t = bcd2int(sh) * 3600 + bcd2int(sm) * 60;
            m_presc = 0; m_tick = 0; m_err = 0;
        end else begin
            m_err = sv;
            m_tick = 0;
            if (e) begin
                if (m_presc == CLK_HZ - 1) begin
                    m_presc = 0;
                    m_t = (m_t + 1) % DAY;
                    m_tick = 1;
                end else begin
                    m_presc = m_presc + 1;
                end
            end else if (!sv) begin
                h = m_t / 3600;
                m = (m_t / 60) % 60;
                s = m_t % 60;
                if (am) m = (m + 1) % 60;
                if (ah) h = (h + 1) % 24;
                m_t = h * 3600 + m * 60 + s;
            end
        end
    endfunction

    function automatic logic [26:0] model_pack();
        logic b;
        b = (m_presc < CLK_HZ / 2);
        return {int2bcd(m_t / 3600), int2bcd((m_t / 60) % 60), int2bcd(m_t % 60), m_tick, b, m_err};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h tick=%b blink=%b err=%b, expected %h:%h:%h tick=%b blink=%b err=%b",
                     name, act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
                     exp[26:19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, e, sv, input logic [7:0] sh, sm, input logic am, ah,
                         output logic [26:0] got);
        rst = r; ena = e; set_valid = sv; set_hour = sh; set_min = sm;
        adv_min = am; adv_hour = ah;
        @(posedge clk);
        model_step(r, e, sv, sh, sm, am, ah);
        exp_q.push_back(model_pack());
        #1;
        got = {hour_bcd, min_bcd, sec_bcd, sec_tick, blink, set_err};
        check("model", got, exp_q.pop_front());
    endtask

    function automatic logic [26:0] pk(input logic [7:0] h, m, s, input logic t, b, er);
        return {h, m, s, t, b, er};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        r, e, sv;
        logic [7:0]  sh, sm;
        logic        am, ah;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic r, e, sv, input logic [7:0] sh, sm,
                                input logic am, ah, input logic [26:0] exp);
        vec_t v;
        v.name = n; v.r = r; v.e = e; v.sv = sv; v.sh = sh; v.sm = sm;
        v.am = am; v.ah = ah; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [26:0] got;
        int n;

        add("reset0",       1,0,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h00,0,1,0));
        add("reset1",       1,0,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h00,0,1,0));
        add("run_p1",       0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h00,0,1,0));
        add("run_p2",       0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h00,0,0,0));
        add("run_p3",       0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h00,0,0,0));
        add("first_tick",   0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h01,1,1,0));
        add("after_tick",   0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h01,0,1,0));
        add("bad_hour24",   0,1,1,8'h24,8'h00,0,0, pk(8'h00,8'h00,8'h01,0,0,1));
        add("bad_min5a",    0,1,1,8'h00,8'h5A,0,0, pk(8'h00,8'h00,8'h01,0,0,1));
        add("tick_cont",    0,1,0,8'h00,8'h00,0,0, pk(8'h00,8'h00,8'h02,1,1,0));
        add("load_stopped", 0,0,1,8'h12,8'h34,0,0, pk(8'h12,8'h34,8'h00,0,1,0));
        add("adv_min",      0,0,0,8'h00,8'h00,1,0, pk(8'h12,8'h35,8'h00,0,1,0));
        add("adv_both",     0,0,0,8'h00,8'h00,1,1, pk(8'h13,8'h36,8'h00,0,1,0));
        add("adv_ena1",     0,1,0,8'h00,8'h00,1,0, pk(8'h13,8'h36,8'h00,0,1,0));
        add("load_0059",    0,0,1,8'h00,8'h59,0,0, pk(8'h00,8'h59,8'h00,0,1,0));
        add("adv_min_wrap", 0,0,0,8'h00,8'h00,1,0, pk(8'h00,8'h00,8'h00,0,1,0));
        add("load_2300",    0,0,1,8'h23,8'h00,0,0, pk(8'h23,8'h00,8'h00,0,1,0));
        add("adv_hr_wrap",  0,0,0,8'h00,8'h00,0,1, pk(8'h00,8'h00,8'h00,0,1,0));
        add("load_0909",    0,0,1,8'h09,8'h09,0,0, pk(8'h09,8'h09,8'h00,0,1,0));
        add("adv_both_bcd", 0,0,0,8'h00,8'h00,1,1, pk(8'h10,8'h10,8'h00,0,1,0));
        add("load_vs_adv",  0,0,1,8'h01,8'h02,1,0, pk(8'h01,8'h02,8'h00,0,1,0));
        add("bad_nib_adv",  0,0,1,8'h1A,8'h00,1,0, pk(8'h01,8'h02,8'h00,0,1,1));
        add("tc_p1",        0,1,0,8'h00,8'h00,0,0, pk(8'h01,8'h02,8'h00,0,1,0));
        add("tc_p2",        0,1,0,8'h00,8'h00,0,0, pk(8'h01,8'h02,8'h00,0,0,0));
        add("tc_p3",        0,1,0,8'h00,8'h00,0,0, pk(8'h01,8'h02,8'h00,0,0,0));
        add("load_at_tc",   0,1,1,8'h12,8'h34,0,0, pk(8'h12,8'h34,8'h00,0,1,0));
        add("post_load_p1", 0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h00,0,1,0));
        add("post_load_p2", 0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h00,0,0,0));
        add("post_load_p3", 0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h00,0,0,0));
        add("tick_4_later", 0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h01,1,1,0));
        add("bad_p1",       0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h01,0,1,0));
        add("bad_p2",       0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h01,0,0,0));
        add("bad_p3",       0,1,0,8'h00,8'h00,0,0, pk(8'h12,8'h34,8'h01,0,0,0));
        add("bad_at_tc",    0,1,1,8'h24,8'h00,0,0, pk(8'h12,8'h34,8'h02,1,1,1));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].sv, vecs[i].sh, vecs[i].sm,
                  vecs[i].am, vecs[i].ah, got);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Midnight rollover: 23:59 load, 59 seconds to 23:59:59, then one edge to 00:00:00.
        drive(0, 1, 1, 8'h23, 8'h59, 0, 0, got);
        check("load_2359", got, pk(8'h23, 8'h59, 8'h00, 0, 1, 0));
        n = 0;
        do begin
            drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
            n++;
        end while (got[26:3] != {8'h23, 8'h59, 8'h59} && n < 300);
        check_int("cycles_to_235959", n, 59 * CLK_HZ);
        for (int i = 0; i < CLK_HZ - 1; i++)
            drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("hold_235959", got, pk(8'h23, 8'h59, 8'h59, 0, 0, 0));
        drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("midnight", got, pk(8'h00, 8'h00, 8'h00, 1, 1, 0));

        // Reset in the middle of a second at 12:34:56.
        drive(0, 1, 1, 8'h12, 8'h34, 0, 0, got);
        for (int i = 0; i < 56 * CLK_HZ; i++)
            drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("at_123456", got, pk(8'h12, 8'h34, 8'h56, 1, 1, 0));
        drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("presc2_123456", got, pk(8'h12, 8'h34, 8'h56, 0, 0, 0));
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("mid_reset", got, pk(8'h00, 8'h00, 8'h00, 0, 1, 0));
        for (int i = 0; i < CLK_HZ; i++)
            drive(0, 1, 0, 8'h00, 8'h00, 0, 0, got);
        check("tick_after_rst", got, pk(8'h00, 8'h00, 8'h01, 1, 1, 0));

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, e, sv, am, ah;
            logic [7:0] sh, sm;
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 9) < 7);
            sv = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                sh = int2bcd($urandom_range(0, 23));
                sm = int2bcd($urandom_range(0, 59));
            end else begin
                sh = 8'($urandom_range(0, 255));
                sm = 8'($urandom_range(0, 255));
            end
            am = ($urandom_range(0, 3) == 0);
            ah = ($urandom_range(0, 3) == 0);
            drive(r, e, sv, sh, sm, am, ah, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
